// File: rtl/tlb_param.sv
// tlb_param: set-associative TLB with age-based replacement and a page-table-walker port.
// Latency: a hit responds 2 cycles after acceptance; a miss goes through the PTW request/response.
// Backpressure: one transaction at a time; requests wait in IDLE; a response is held until resp_ready_i.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_*/vaddr_i/access_type_i translation request (access_type_i: 0 read, 1 write)
//   resp_*/paddr_o/hit_o/fault_o translation response
//   ptw_req_*/ptw_vaddr_o       page-walk request
//   ptw_resp_*/ptw_pte_i        page-walk response (PTE: [0]=V [1]=R [2]=W [31:12]=PPN)
//   flush_valid_i/flush_ready_o invalidate all entries
// Optional: define TLB_PERF_CNT_EN to add hit_cnt_o, miss_cnt_o and fault_cnt_o counters.
module tlb_param #(
  parameter int NUM_SETS    = 4,
  parameter int NUM_WAYS    = 4,
  parameter int PTW_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] vaddr_i,
  input  logic        access_type_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] paddr_o,
  output logic        hit_o,
  output logic        fault_o,
  output logic        ptw_req_valid_o,
  input  logic        ptw_req_ready_i,
  output logic [31:0] ptw_vaddr_o,
  input  logic        ptw_resp_valid_i,
  output logic        ptw_resp_ready_o,
  input  logic [31:0] ptw_pte_i,
  input  logic        flush_valid_i,
  output logic        flush_ready_o
`ifdef TLB_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
  output logic [31:0] fault_cnt_o
`endif
);

  localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int WAY_W = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    PTW_REQ,
    PTW_WAIT,
    RESPOND
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic        acc_q, acc_d;
  logic [31:0] paddr_q, paddr_d;
  logic        hit_q, hit_d;
  logic        fault_q, fault_d;
  logic [31:0] ptw_vaddr_q, ptw_vaddr_d;
  logic [31:0] tmo_q, tmo_d;

  // Entry storage
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] r_q     [NUM_SETS];
  logic [NUM_WAYS-1:0] w_q     [NUM_SETS];
  logic [19:0]         tag_q   [NUM_SETS][NUM_WAYS];
  logic [19:0]         ppn_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];

  // Set index of the captured request
  logic [SET_W-1:0] set_idx;
  always_comb begin
    set_idx = '0;
    if (NUM_SETS > 1) set_idx = vaddr_q[12 +: SET_W];
  end

  // Tag match (first matching way wins; a VPN is only ever filled once per set)
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [19:0]      hit_ppn;
  logic             hit_r, hit_w;
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    hit_ppn = '0;
    hit_r   = 1'b0;
    hit_w   = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!hit_any && valid_q[set_idx][i] && (tag_q[set_idx][i] == vaddr_q[31:12])) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(i);
        hit_ppn = ppn_q[set_idx][i];
        hit_r   = r_q[set_idx][i];
        hit_w   = w_q[set_idx][i];
      end
    end
  end

  // Victim: lowest invalid way, otherwise the oldest way
  logic             inv_found;
  logic [WAY_W-1:0] victim_way;
  always_comb begin
    inv_found  = 1'b0;
    victim_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!inv_found && !valid_q[set_idx][i]) begin
        inv_found  = 1'b1;
        victim_way = WAY_W'(i);
      end
    end
    if (!inv_found) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (age_q[set_idx][i] == WAY_W'(NUM_WAYS - 1)) victim_way = WAY_W'(i);
      end
    end
  end

  // PTE fields
  logic        pte_v, pte_r, pte_w;
  logic [19:0] pte_ppn;
  logic        unused_pte;
  assign pte_v      = ptw_pte_i[0];
  assign pte_r      = ptw_pte_i[1];
  assign pte_w      = ptw_pte_i[2];
  assign pte_ppn    = ptw_pte_i[31:12];
  assign unused_pte = ^ptw_pte_i[11:3];

  logic hit_perm_ok, pte_perm_ok;
  assign hit_perm_ok = acc_q ? hit_w : hit_r;
  assign pte_perm_ok = acc_q ? pte_w : pte_r;

  logic timeout_hit;
  assign timeout_hit = (PTW_TIMEOUT != 0) && (tmo_q == 32'(PTW_TIMEOUT - 1));

  // Array update controls
  logic             flush_en;
  logic             touch_en;
  logic             fill_en;
  logic [WAY_W-1:0] touch_way;
  logic [WAY_W-1:0] touch_age;
  assign touch_age = age_q[set_idx][touch_way];

  always_comb begin
    state_d     = state_q;
    vaddr_d     = vaddr_q;
    acc_d       = acc_q;
    paddr_d     = paddr_q;
    hit_d       = hit_q;
    fault_d     = fault_q;
    ptw_vaddr_d = ptw_vaddr_q;
    tmo_d       = '0;
    flush_en    = 1'b0;
    touch_en    = 1'b0;
    fill_en     = 1'b0;
    touch_way   = '0;
    case (state_q)
      IDLE: begin
        if (flush_valid_i) begin
          flush_en = 1'b1;
        end else if (req_valid_i) begin
          vaddr_d = vaddr_i;
          acc_d   = access_type_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_any) begin
          touch_en  = 1'b1;
          touch_way = hit_way;
          hit_d     = 1'b1;
          fault_d   = !hit_perm_ok;
          paddr_d   = hit_perm_ok ? {hit_ppn, vaddr_q[11:0]} : 32'd0;
          state_d   = RESPOND;
        end else begin
          ptw_vaddr_d = vaddr_q;
          state_d     = PTW_REQ;
        end
      end
      PTW_REQ: begin
        if (ptw_req_ready_i) state_d = PTW_WAIT;
      end
      PTW_WAIT: begin
        // A response in the final timeout cycle still wins over the timeout
        if (ptw_resp_valid_i) begin
          hit_d   = 1'b0;
          state_d = RESPOND;
          if (!pte_v) begin
            fault_d = 1'b1;
            paddr_d = 32'd0;
          end else begin
            touch_en  = 1'b1;
            fill_en   = 1'b1;
            touch_way = victim_way;
            fault_d   = !pte_perm_ok;
            paddr_d   = pte_perm_ok ? {pte_ppn, vaddr_q[11:0]} : 32'd0;
          end
        end else if (timeout_hit) begin
          hit_d   = 1'b0;
          fault_d = 1'b1;
          paddr_d = 32'd0;
          state_d = RESPOND;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      RESPOND: begin
        if (resp_ready_i) begin
          paddr_d = 32'd0;
          hit_d   = 1'b0;
          fault_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vaddr_q     <= '0;
      acc_q       <= 1'b0;
      paddr_q     <= '0;
      hit_q       <= 1'b0;
      fault_q     <= 1'b0;
      ptw_vaddr_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      vaddr_q     <= vaddr_d;
      acc_q       <= acc_d;
      paddr_q     <= paddr_d;
      hit_q       <= hit_d;
      fault_q     <= fault_d;
      ptw_vaddr_q <= ptw_vaddr_d;
      tmo_q       <= tmo_d;
    end
  end

  // Tag/PPN/permission storage carries no reset; valid bits gate it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else if (flush_en) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else if (touch_en) begin
      if (fill_en) begin
        valid_q[set_idx][touch_way] <= 1'b1;
        r_q[set_idx][touch_way]     <= pte_r;
        w_q[set_idx][touch_way]     <= pte_w;
        tag_q[set_idx][touch_way]   <= vaddr_q[31:12];
        ppn_q[set_idx][touch_way]   <= pte_ppn;
      end
      // Younger ways age by one, touched way becomes youngest: ages stay a permutation
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[set_idx][w] < touch_age) age_q[set_idx][w] <= age_q[set_idx][w] + WAY_W'(1);
      end
      age_q[set_idx][touch_way] <= '0;
    end
  end

  assign req_ready_o      = (state_q == IDLE);
  assign flush_ready_o    = (state_q == IDLE);
  assign ptw_req_valid_o  = (state_q == PTW_REQ);
  assign ptw_resp_ready_o = (state_q == PTW_WAIT);
  assign resp_valid_o     = (state_q == RESPOND);
  assign paddr_o          = paddr_q;
  assign hit_o            = hit_q;
  assign fault_o          = fault_q;
  assign ptw_vaddr_o      = ptw_vaddr_q;

`ifdef TLB_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, fault_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      fault_cnt_q <= '0;
    end else begin
      if (state_q == LOOKUP && hit_any)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (state_q == LOOKUP && !hit_any) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == RESPOND && resp_ready_i && fault_q) fault_cnt_q <= fault_cnt_q + 32'd1;
    end
  end
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;
  assign fault_cnt_o = fault_cnt_q;
`endif

endmodule
